// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: CPU load/store request and response bus for the data memory target.
// The master modport is the CPU side and the slave modport is the memory side.
interface data_mem_responder_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
    logic              ack;
    logic              err;
    logic [31:0]       rdata;
    logic              busy;

    modport master (
        output req, we, addr, wdata, be,
        input  ack, err, rdata, busy
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ack, err, rdata, busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: handshaked multi-cycle data memory with WAIT_CYCLES wait states per access.
// Defining DMEM_ACCESS_CNT_EN adds the rd_count/wr_count successful-access counters.
module data_mem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                clock,
    input  logic                reset,
`ifdef DMEM_ACCESS_CNT_EN
    output logic [CNT_W-1:0]    rd_count,
    output logic [CNT_W-1:0]    wr_count,
`endif
    data_mem_responder_if.slave bus
);

    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_BITS = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic                busy_q;
    logic                ack_q;
    logic                err_q;
    logic [31:0]         rdata_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [3:0]          be_q;
    logic [31:0]         mem_q [DEPTH];

`ifdef DMEM_ACCESS_CNT_EN
    logic [CNT_W-1:0]    rdCnt_q;
    logic [CNT_W-1:0]    wrCnt_q;
`endif

    logic                accept;
    logic                finishAccess;
    logic                we_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [31:0]         wdata_d;
    logic [3:0]          be_d;
    logic [ADDR_W-1:0]   wordIdx;
    logic                accessErr;
    logic [IDX_W-1:0]    memIdx;

    // Requests are only sampled in IDLE, so back-to-back accesses keep a one-cycle gap
    // and ack stays a single-cycle pulse. With zero wait states the access completes on
    // the acceptance edge itself, hence the live inputs feed the operand mux.
    always_comb begin
        accept       = bus.req && (state_q == S_IDLE);
        we_d         = accept ? bus.we    : we_q;
        addr_d       = accept ? bus.addr  : addr_q;
        wdata_d      = accept ? bus.wdata : wdata_q;
        be_d         = accept ? bus.be    : be_q;
        wordIdx      = {2'b00, addr_d[ADDR_W-1:2]};
        accessErr    = (addr_d[1:0] != 2'b00) || (wordIdx >= ADDR_W'(DEPTH));
        memIdx       = wordIdx[IDX_W-1:0];
        finishAccess = ((state_q == S_WAIT) && (cnt_q == CNT_BITS'(1)))
                    || (accept && (WAIT_CYCLES == 0));
    end

    always_ff @(posedge clock) begin
        if (!reset && finishAccess && we_d && !accessErr) begin
            for (int i = 0; i < 4; i++) begin
                if (be_d[i]) begin
                    mem_q[memIdx][8*i +: 8] <= wdata_d[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
`ifdef DMEM_ACCESS_CNT_EN
            rdCnt_q <= '0;
            wrCnt_q <= '0;
`endif
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        we_q    <= we_d;
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        be_q    <= be_d;
                        cnt_q   <= CNT_BITS'(WAIT_CYCLES);
                        busy_q  <= 1'b1;
                        state_q <= (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - CNT_BITS'(1);
                    if (cnt_q == CNT_BITS'(1)) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase

            // Loads and errors update rdata; stores leave the last load result visible.
            if (finishAccess) begin
                ack_q <= 1'b1;
                err_q <= accessErr;
                if (accessErr) begin
                    rdata_q <= '0;
                end else if (!we_d) begin
                    rdata_q <= mem_q[memIdx];
                end
`ifdef DMEM_ACCESS_CNT_EN
                if (!accessErr && we_d) begin
                    wrCnt_q <= wrCnt_q + CNT_W'(1);
                end
                if (!accessErr && !we_d) begin
                    rdCnt_q <= rdCnt_q + CNT_W'(1);
                end
`endif
            end
        end
    end

    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;

`ifdef DMEM_ACCESS_CNT_EN
    assign rd_count = rdCnt_q;
    assign wr_count = wrCnt_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: drives two responders (2 and 0 wait states) against a word-array
// reference model; also covers the DMEM_ACCESS_CNT_EN counters when that macro is defined.
module tb_data_mem_responder;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 256;
    localparam int CNT_W  = 16;
    localparam int WAIT_A = 2;
    localparam int WAIT_B = 0;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    data_mem_responder_if #(.ADDR_W(ADDR_W)) busA ();
    data_mem_responder_if #(.ADDR_W(ADDR_W)) busB ();

`ifdef DMEM_ACCESS_CNT_EN
    logic [CNT_W-1:0] rdCountA, wrCountA, rdCountB, wrCountB;
`endif

    data_mem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_A), .CNT_W(CNT_W)) dutA (
        .clock    (clock),
        .reset    (reset),
`ifdef DMEM_ACCESS_CNT_EN
        .rd_count (rdCountA),
        .wr_count (wrCountA),
`endif
        .bus      (busA)
    );

    data_mem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_B), .CNT_W(CNT_W)) dutB (
        .clock    (clock),
        .reset    (reset),
`ifdef DMEM_ACCESS_CNT_EN
        .rd_count (rdCountB),
        .wr_count (wrCountB),
`endif
        .bus      (busB)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one word array per responder plus the expected held rdata and counts.
    logic [31:0]      refMem   [2][DEPTH];
    bit               known    [2][DEPTH];
    logic [31:0]      refRdata [2];
    logic [CNT_W-1:0] refRd    [2];
    logic [CNT_W-1:0] refWr    [2];
    int               waitOf   [2] = '{WAIT_A, WAIT_B};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic driveBus(input int sel, input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
        if (sel == 0) begin
            busA.req = req; busA.we = we; busA.addr = addr; busA.wdata = wdata; busA.be = be;
        end else begin
            busB.req = req; busB.we = we; busB.addr = addr; busB.wdata = wdata; busB.be = be;
        end
    endtask

    // Packed as {busy, err, ack, rdata}.
    function automatic logic [34:0] sampleBus(input int sel);
        if (sel == 0) return {busA.busy, busA.err, busA.ack, busA.rdata};
        return {busB.busy, busB.err, busB.ack, busB.rdata};
    endfunction

`ifdef DMEM_ACCESS_CNT_EN
    function automatic logic [2*CNT_W-1:0] sampleCnt(input int sel);
        if (sel == 0) return {rdCountA, wrCountA};
        return {rdCountB, wrCountB};
    endfunction
`endif

    task automatic clearModelOnReset();
        for (int s = 0; s < 2; s++) begin
            refRdata[s] = '0;
            refRd[s]    = '0;
            refWr[s]    = '0;
        end
    endtask

    // One complete access starting from an idle responder at a negedge; inputs are scrambled
    // while busy. Returns at the negedge of the idle cycle that follows the ack.
    task automatic applyStimulus(input int sel, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be, input bit holdReq);
        int          w;
        bit          isErr;
        logic [31:0] idx;
        logic [31:0] mask;
        logic [34:0] s;
`ifdef DMEM_ACCESS_CNT_EN
        logic [2*CNT_W-1:0] c;
`endif
        w     = waitOf[sel];
        idx   = addr >> 2;
        isErr = (addr[1:0] != 2'b00) || (idx >= 32'(DEPTH));
        mask  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        if (isErr) begin
            refRdata[sel] = '0;
        end else if (we) begin
            refMem[sel][idx] = (refMem[sel][idx] & ~mask) | (wdata & mask);
            known[sel][idx]  = 1'b1;
            refWr[sel]       = refWr[sel] + 1'b1;
        end else begin
            refRdata[sel] = refMem[sel][idx];
            refRd[sel]    = refRd[sel] + 1'b1;
        end

        driveBus(sel, 1'b1, we, addr, wdata, be);
        for (int k = 1; k <= w + 1; k++) begin
            @(negedge clock);
            s = sampleBus(sel);
            checkOutput($sformatf("dut%0d ack c%0d @%08h", sel, k, addr), 32'(s[32]), 32'(k == w + 1));
            checkOutput($sformatf("dut%0d busy c%0d", sel, k), 32'(s[34]), 32'd1);
            if (k == w + 1) begin
                checkOutput($sformatf("dut%0d err @%08h", sel, addr), 32'(s[33]), 32'(isErr));
                checkOutput($sformatf("dut%0d rdata @%08h", sel, addr), s[31:0], refRdata[sel]);
`ifdef DMEM_ACCESS_CNT_EN
                c = sampleCnt(sel);
                checkOutput($sformatf("dut%0d rd_count", sel), 32'(c[2*CNT_W-1:CNT_W]), 32'(refRd[sel]));
                checkOutput($sformatf("dut%0d wr_count", sel), 32'(c[CNT_W-1:0]), 32'(refWr[sel]));
`endif
            end
            driveBus(sel, holdReq ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom, $urandom, 4'($urandom_range(0, 15)));
        end
        @(negedge clock);
        s = sampleBus(sel);
        checkOutput($sformatf("dut%0d ack idle", sel), 32'(s[32]), 32'd0);
        checkOutput($sformatf("dut%0d busy idle", sel), 32'(s[34]), 32'd0);
        driveBus(sel, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          sel;
        int          word;
        int          kind;
        logic        we;
        logic [31:0] addr;
        logic [34:0] s;

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) begin
                refMem[d][i] = '0;
                known[d][i]  = 1'b0;
            end
        end
        clearModelOnReset();
        driveBus(0, 1'b0, 1'b0, '0, '0, '0);
        driveBus(1, 1'b0, 1'b0, '0, '0, '0);

        $display("[TB] reset held for two cycles");
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            s = sampleBus(d);
            checkOutput($sformatf("dut%0d reset ack", d), 32'(s[32]), 32'd0);
            checkOutput($sformatf("dut%0d reset err", d), 32'(s[33]), 32'd0);
            checkOutput($sformatf("dut%0d reset busy", d), 32'(s[34]), 32'd0);
            checkOutput($sformatf("dut%0d reset rdata", d), s[31:0], 32'd0);
        end
        reset = 1'b0;
        @(negedge clock);

        $display("[TB] full-word store and load with wait states");
        applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0);
        checkOutput("t2 rdata held", busA.rdata, 32'hDEADBEEF);

        applyStimulus(0, 1'b1, 32'h20, 32'h12345678, 4'b1111, 1'b0);
        applyStimulus(0, 1'b1, 32'h00, 32'h0BADF00D, 4'b1111, 1'b0);
        applyStimulus(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b0);

        $display("[TB] byte-enabled store");
        applyStimulus(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b0);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0);
        checkOutput("t3 merged word", busA.rdata, 32'hDE22BE44);

        $display("[TB] misaligned and out-of-range loads");
        applyStimulus(0, 1'b0, 32'h13, 32'h0, 4'b0000, 1'b0);
        applyStimulus(0, 1'b0, 32'(DEPTH * 4), 32'h0, 4'b0000, 1'b0);
        applyStimulus(0, 1'b1, 32'h8000_0000, 32'hAAAAAAAA, 4'b1111, 1'b0);
        applyStimulus(0, 1'b0, 32'h00, 32'h0, 4'b0000, 1'b0);
        checkOutput("t4 word0 intact", busA.rdata, 32'h0BADF00D);

        $display("[TB] reset during a pending store");
        driveBus(0, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 4'b1111);
        @(negedge clock);
        checkOutput("t6 busy before abort", 32'(busA.busy), 32'd1);
        reset = 1'b1;
        driveBus(0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clock);
        @(negedge clock);
        clearModelOnReset();
        checkOutput("t6 busy in reset", 32'(busA.busy), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checkOutput($sformatf("t6 no ack c%0d", k), 32'(busA.ack), 32'd0);
        end
        applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'b0000, 1'b0);
        checkOutput("t6 old value", busA.rdata, 32'h12345678);

        $display("[TB] zero wait states, back-to-back loads with req held");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1'b1, 32'(i * 4), $urandom, 4'b1111, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1'b0, 32'(12 - i * 4), 32'h0, 4'b0000, 1'b1);
        end

        $display("[TB] randomized accesses on both responders");
        for (int n = 0; n < 120; n++) begin
            sel  = n % 2;
            kind = $urandom_range(0, 9);
            word = $urandom_range(0, 15);
            we   = 1'($urandom_range(0, 1));
            if (kind == 0) begin
                addr = 32'(word * 4 + $urandom_range(1, 3));
            end else if (kind == 1) begin
                addr = 32'($urandom_range(DEPTH, 32'h3FFF_FFFF)) << 2;
            end else begin
                addr = 32'(word * 4);
                if (!we && !known[sel][word]) we = 1'b1;
            end
            applyStimulus(sel, we, addr, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
